// File: rtl/lat_tester_ctrl.sv
// lat_tester_ctrl: latency-tester sequencer between the host registers and the 720x480 pattern generator.
// Optional LT_AVG_EN: each start averages four back-to-back measurements.
module lat_tester_ctrl #(
    parameter logic [23:0] TIMEOUT_CYC  = 24'd8100000,
    parameter logic [7:0]  DEBOUNCE_CYC = 8'd16,
    parameter logic [15:0] DARK_CYC     = 16'd2700,
    parameter logic [3:0]  HOLD_FRAMES  = 4'd3
) (
    input  logic        clk27,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode_sel,
    input  logic        vsync_in,
    input  logic        sensor_in,
    output logic        lt_active,
    output logic [1:0]  lt_mode,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [23:0] result
);
    localparam logic [23:0] RES_TMO = 24'hFFFFFF;
    localparam logic [23:0] LAT_MAX = 24'hFFFFFE;

    typedef enum logic [2:0] {IDLE, DARK, SYNC, FLASH, HOLD, RELEASE} state_t;
    state_t state, state_n;

    logic        sens_m, sens_s, vs_prev, vs_fall;
    logic [15:0] dark_cnt;
    logic [23:0] tmo_cnt, lat_cnt, cand, cand_now;
    logic [7:0]  deb_cnt, deb_next;
    logic [3:0]  frame_cnt;
    logic        dark_hit, tmo_hit, hold_hit, last_run;
    logic        accept, tmo_fire, deb_hit, rel_ok, rel_tmo;
    logic        finish, tmo_clr, dark_run, flash_go;

`ifdef LT_AVG_EN
    logic [1:0]  run_cnt;
    logic [25:0] acc;
    assign last_run = (run_cnt == 2'd3);
`else
    assign last_run = 1'b1;
`endif

    assign vs_fall  = vs_prev & ~vsync_in;
    assign dark_hit = ~sens_s && (dark_cnt == DARK_CYC - 16'd1);
    assign tmo_hit  = (tmo_cnt == TIMEOUT_CYC - 24'd1);
    assign hold_hit = vs_fall && (frame_cnt == HOLD_FRAMES - 4'd1);
    // First high sample of a run starts a new candidate at the current latency.
    assign deb_next = (deb_cnt == '0) ? 8'd1 : deb_cnt + 8'd1;
    assign cand_now = (deb_cnt == '0) ? lat_cnt : cand;

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        tmo_fire = 1'b0;
        deb_hit  = 1'b0;
        rel_ok   = 1'b0;
        rel_tmo  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = DARK;
                end
            end
            DARK: begin
                if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_n  = IDLE;
                end else if (dark_hit) begin
                    state_n = SYNC;
                end
            end
            SYNC: begin
                if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_n  = IDLE;
                end else if (vs_fall) begin
                    state_n = FLASH;
                end
            end
            FLASH: begin
                // Detection takes priority over a timeout landing on the same cycle.
                if (sens_s && (deb_next == DEBOUNCE_CYC)) begin
                    deb_hit = 1'b1;
                    state_n = HOLD;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_n  = IDLE;
                end
            end
            HOLD: begin
                if (hold_hit) state_n = RELEASE;
            end
            RELEASE: begin
                if (dark_hit) begin
                    rel_ok  = 1'b1;
                    state_n = last_run ? IDLE : DARK;
                end else if (tmo_hit) begin
                    rel_tmo = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign finish   = rel_ok & last_run;
    assign flash_go = (state == SYNC) && (state_n == FLASH);
    assign dark_run = ((state == DARK) || (state == RELEASE)) && (state_n == state);
    // RELEASE reuses the measurement timeout counter with a fresh start.
    assign tmo_clr  = accept || ((state == HOLD) && (state_n == RELEASE)) || (rel_ok && !last_run);

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            sens_m    <= 1'b0;
            sens_s    <= 1'b0;
            vs_prev   <= 1'b0;
            dark_cnt  <= '0;
            tmo_cnt   <= '0;
            lat_cnt   <= '0;
            cand      <= '0;
            deb_cnt   <= '0;
            frame_cnt <= '0;
            lt_active <= 1'b0;
            lt_mode   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            result    <= '0;
`ifdef LT_AVG_EN
            run_cnt   <= '0;
            acc       <= '0;
`endif
        end else begin
            sens_m  <= sensor_in;
            sens_s  <= sens_m;
            vs_prev <= vsync_in;
            done    <= 1'b0;

            dark_cnt <= (dark_run && !sens_s) ? dark_cnt + 16'd1 : '0;

            if (tmo_clr)
                tmo_cnt <= '0;
            else if ((state != IDLE) && (state != HOLD))
                tmo_cnt <= tmo_cnt + 24'd1;

            if (flash_go)
                lat_cnt <= 24'd1;
            else if ((state == FLASH) && (lat_cnt != LAT_MAX))
                lat_cnt <= lat_cnt + 24'd1;

            if ((state == FLASH) && sens_s) begin
                deb_cnt <= deb_next;
                cand    <= cand_now;
            end else begin
                deb_cnt <= '0;
            end

            frame_cnt <= (state == HOLD) ? frame_cnt + {3'b000, vs_fall} : '0;

            if (accept) begin
                lt_mode <= mode_sel;
                busy    <= 1'b1;
                timeout <= 1'b0;
            end
            if (flash_go)
                lt_active <= 1'b1;
            if (((state == HOLD) && hold_hit) || tmo_fire)
                lt_active <= 1'b0;
            if (tmo_fire || rel_tmo || finish) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (tmo_fire || rel_tmo)
                timeout <= 1'b1;

`ifdef LT_AVG_EN
            if (accept) begin
                run_cnt <= '0;
                acc     <= '0;
            end else begin
                if (deb_hit)
                    acc <= acc + {2'b00, cand_now};
                if (rel_ok && !last_run)
                    run_cnt <= run_cnt + 2'd1;
            end
            if (tmo_fire || rel_tmo)
                result <= RES_TMO;
            else if (finish)
                result <= acc[25:2];
`else
            if (tmo_fire)
                result <= RES_TMO;
            else if (deb_hit)
                result <= cand_now;
`endif
        end
    end
endmodule

// File: tb/tb_lat_tester_ctrl.sv
// Directed bench for lat_tester_ctrl with shortened timing parameters.
module tb_lat_tester_ctrl;
    localparam int VS_PER = 400;
    localparam int VS_LOW = 4;
    localparam int DARK   = 50;
    localparam int TMO    = 3000;
    localparam int HOLD   = 3;

    logic        clk27 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode_sel = 2'b00;
    logic        vsync_in = 1'b1;
    logic        sensor_in = 1'b0;
    logic        lt_active, busy, done, timeout;
    logic [1:0]  lt_mode;
    logic [23:0] result;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    lat_tester_ctrl #(
        .TIMEOUT_CYC (24'd3000),
        .DEBOUNCE_CYC(8'd16),
        .DARK_CYC    (16'd50),
        .HOLD_FRAMES (4'd3)
    ) dut (
        .clk27    (clk27),
        .reset    (reset),
        .start    (start),
        .mode_sel (mode_sel),
        .vsync_in (vsync_in),
        .sensor_in(sensor_in),
        .lt_active(lt_active),
        .lt_mode  (lt_mode),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .result   (result)
    );

    initial forever #5 clk27 = ~clk27;
    initial forever begin
        @(posedge clk27);
        cyc = cyc + 1;
    end
    // vs_fall lands in every cycle c with c % VS_PER == VS_PER - VS_LOW.
    initial forever begin
        @(negedge clk27);
        vsync_in = ((cyc % VS_PER) < (VS_PER - VS_LOW));
    end

    function automatic int exp_rise(input int s);
        int c;
        c = s + DARK;
        while ((c % VS_PER) != (VS_PER - VS_LOW)) c++;
        return c + 1;
    endfunction

    task automatic do_start(input logic [1:0] m, output int s);
        @(negedge clk27);
        mode_sel = m;
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk27);
        start = 1'b0;
        mode_sel = 2'b00;
    endtask

    task automatic wait_lt(input logic lvl, input int limit, output bit ok);
        int n;
        n = 0;
        while (lt_active !== lvl && n < limit) begin
            @(negedge clk27);
            n++;
        end
        ok = (lt_active === lvl);
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk27);
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk27);
        n_checks++; if (lt_active !== 1'b0) begin n_fail++; $display("FAIL reset_lt_active: got %b expected 0", lt_active); end
        n_checks++; if (lt_mode !== 2'b00) begin n_fail++; $display("FAIL reset_lt_mode: got %b expected 00", lt_mode); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        n_checks++; if (result !== 24'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int s, rise, fall, er;
        bit ok;
        do_start(2'b01, s);
        n_checks++; if (lt_mode !== 2'b01) begin n_fail++; $display("FAIL single_lt_mode: got %b expected 01", lt_mode); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        er = exp_rise(s);
        wait_lt(1'b1, 2000, ok);
        rise = cyc;
        n_checks++; if (!ok || rise != er) begin n_fail++; $display("FAIL single_rise_cycle: got %0d expected %0d", rise, er); end
        repeat (99) @(negedge clk27);
        sensor_in = 1'b1;
        wait_lt(1'b0, 3000, ok);
        fall = cyc;
        n_checks++; if (!ok || fall != rise + HOLD * VS_PER) begin n_fail++; $display("FAIL single_hold_len: got %0d expected %0d", fall - rise, HOLD * VS_PER); end
        sensor_in = 1'b0;
        wait_done(500, ok);
        n_checks++; if (!ok || cyc != fall + DARK + 2) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected %0d", cyc - fall, DARK + 2); end
        n_checks++; if (result !== 24'd102) begin n_fail++; $display("FAIL single_result: got %0d expected 102", result); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b expected 0", timeout); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done: got %b expected 0", busy); end
        @(negedge clk27);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b expected 0", done); end
    endtask

    task automatic test_glitch();
        int s;
        bit ok;
        do_start(2'b10, s);
        n_checks++; if (lt_mode !== 2'b10) begin n_fail++; $display("FAIL glitch_lt_mode: got %b expected 10", lt_mode); end
        wait_lt(1'b1, 2000, ok);
        n_checks++; if (!ok || cyc != exp_rise(s)) begin n_fail++; $display("FAIL glitch_rise_cycle: got %0d expected %0d", cyc, exp_rise(s)); end
        repeat (39) @(negedge clk27);
        sensor_in = 1'b1;
        repeat (5) @(negedge clk27);
        sensor_in = 1'b0;
        repeat (45) @(negedge clk27);
        sensor_in = 1'b1;
        wait_lt(1'b0, 3000, ok);
        sensor_in = 1'b0;
        wait_done(500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL glitch_done_seen: got 0 expected 1"); end
        n_checks++; if (result !== 24'd92) begin n_fail++; $display("FAIL glitch_result: got %0d expected 92", result); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL glitch_timeout: got %b expected 0", timeout); end
    endtask

    // Sensor timed so the debounce completes on the timeout cycle (late=0) or one cycle after (late=1).
    task automatic test_tmo_edge(input int late);
        int s, rise, k;
        bit ok;
        do_start(2'b11, s);
        wait_lt(1'b1, 2000, ok);
        rise = cyc;
        k = s + TMO - 1 - rise - 17 + late;
        repeat (k) @(negedge clk27);
        sensor_in = 1'b1;
        if (late == 0) begin
            wait_lt(1'b0, 3000, ok);
            sensor_in = 1'b0;
            wait_done(500, ok);
            n_checks++; if (!ok || result !== 24'(k + 3)) begin n_fail++; $display("FAIL tie_result: got %0d expected %0d", result, k + 3); end
            n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tie_timeout: got %b expected 0", timeout); end
        end else begin
            wait_done(500, ok);
            n_checks++; if (!ok || cyc != s + TMO) begin n_fail++; $display("FAIL late_done_cycle: got %0d expected %0d", cyc - s, TMO); end
            n_checks++; if (result !== 24'hFFFFFF) begin n_fail++; $display("FAIL late_result: got %h expected ffffff", result); end
            n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL late_timeout: got %b expected 1", timeout); end
            sensor_in = 1'b0;
            repeat (10) @(negedge clk27);
        end
    endtask

    task automatic test_timeout();
        int s;
        bit ok;
        do_start(2'b01, s);
        wait_done(TMO + 100, ok);
        n_checks++; if (!ok || cyc != s + TMO) begin n_fail++; $display("FAIL tmo_done_cycle: got %0d expected %0d", cyc - s, TMO); end
        n_checks++; if (result !== 24'hFFFFFF) begin n_fail++; $display("FAIL tmo_result: got %h expected ffffff", result); end
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b expected 1", timeout); end
        n_checks++; if (lt_active !== 1'b0) begin n_fail++; $display("FAIL tmo_lt_active: got %b expected 0", lt_active); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b expected 0", busy); end
        repeat (5) @(negedge clk27);
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 1", timeout); end
        do_start(2'b10, s);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_cleared_by_start: got %b expected 0", timeout); end
    endtask

    // Continues the run started at the end of test_timeout.
    task automatic test_reset_mid();
        int dones;
        bit ok;
        wait_lt(1'b1, 2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_mid_flash: got lt_active %b expected 1", lt_active); end
        repeat (20) @(negedge clk27);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (lt_active !== 1'b0) begin n_fail++; $display("FAIL rst_mid_lt_active: got %b expected 0", lt_active); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        @(negedge clk27);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk27);
            if (i == 100) sensor_in = 1'b1;
            if (i == 300) sensor_in = 1'b0;
            if (done === 1'b1) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d strobes expected 0", dones); end
        n_checks++; if (result !== 24'd0) begin n_fail++; $display("FAIL rst_mid_result: got %0d expected 0", result); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_tmo_edge(0);
        test_tmo_edge(1);
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
